// File: rtl/fu_issue_fifo_n_pkg.sv
// Shared definitions for the functional-unit issue FIFO.
// Provides the default FIFO depth and the issue-packet payload type.
`ifndef SYS_IS_FIFO_DEPTH
`define SYS_IS_FIFO_DEPTH 8
`endif

package fu_issue_fifo_n_pkg;

    // Payload width of an issue packet as produced by the reservation stations
    localparam int unsigned ISSUE_PKT_W   = 64;
    // System-wide default issue FIFO depth
    localparam int unsigned IS_FIFO_DEPTH = `SYS_IS_FIFO_DEPTH;

    // Packet alias used when DATA_W is bound to ISSUE_PKT_W
    typedef logic [ISSUE_PKT_W-1:0] issue_pkt_t;

endpackage

// File: rtl/fu_issue_fifo_n_lane_compactor.sv
// Lane compactor: exclusive prefix-sum rank per lane plus total popcount.
// Ports:
//   valid  in   N         per-lane request bits
//   rank   out  N*RW      rank of lane i = number of set lanes below i
//   total  out  RW        popcount(valid)
module fu_issue_fifo_n_lane_compactor #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]                  valid,
    output logic [N*$clog2(N+1)-1:0]      rank,
    output logic [$clog2(N+1)-1:0]        total
);

    localparam int unsigned RW = $clog2(N+1);

    // Running count: each lane's rank is the sum of the lanes before it
    always_comb begin
        total = '0;
        rank  = '0;
        for (int i = 0; i < int'(N); i++) begin
            rank[i*RW +: RW] = total;
            total            = total + RW'(valid[i]);
        end
    end

endmodule

// File: rtl/fu_issue_fifo_n.sv
// Multi-lane issue FIFO between reservation-station issue ports and one FU class.
// Circular buffer with head/tail pointers, same-cycle bypass, flush and sticky overflow.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               squash all contents (outputs gated off this cycle)
//   in_valid/in_data    IN_W push lanes, lane 0 oldest
//   out_ready           OUT_W FU lanes able to accept
//   out_valid/out_data  dispatched packets (data zero on idle lanes)
//   almost_full         registered, count >= DEPTH - AF_MARGIN
//   count               registered occupancy
//   overflow            sticky: a valid push was dropped
module fu_issue_fifo_n
    import fu_issue_fifo_n_pkg::*;
#(
    parameter int unsigned DEPTH     = IS_FIFO_DEPTH,
    parameter int unsigned IN_W      = 3,
    parameter int unsigned OUT_W     = 3,
    parameter int unsigned DATA_W    = ISSUE_PKT_W,
    parameter int unsigned AF_MARGIN = IN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [IN_W-1:0]           in_valid,
    input  logic [IN_W*DATA_W-1:0]    in_data,
    input  logic [OUT_W-1:0]          out_ready,
    output logic [OUT_W-1:0]          out_valid,
    output logic [OUT_W*DATA_W-1:0]   out_data,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned IRW = $clog2(IN_W + 1);
    localparam int unsigned ORW = $clog2(OUT_W + 1);
    // Wide enough for count + accepted and rank arithmetic without wrap
    localparam int unsigned AW  = $clog2(DEPTH + IN_W + OUT_W + 1) + 1;

    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               almost_full_q, almost_full_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];

    logic [IN_W*IRW-1:0]  in_rank_flat;
    logic [IRW-1:0]       in_cnt;
    logic [OUT_W*ORW-1:0] rdy_rank_flat;
    logic [ORW-1:0]       rdy_cnt;
    logic [AW-1:0]        in_rank  [IN_W];
    logic [AW-1:0]        rdy_rank [OUT_W];

    logic [AW-1:0] wr, free_slots, accepted, avail, rd;
    logic          drop;

    fu_issue_fifo_n_lane_compactor #(.N(IN_W)) u_in_cmp (
        .valid (in_valid),
        .rank  (in_rank_flat),
        .total (in_cnt)
    );

    fu_issue_fifo_n_lane_compactor #(.N(OUT_W)) u_rdy_cmp (
        .valid (out_ready),
        .rank  (rdy_rank_flat),
        .total (rdy_cnt)
    );

    // Unpack ranks into common arithmetic width
    always_comb begin
        for (int i = 0; i < int'(IN_W); i++) begin
            in_rank[i] = AW'(in_rank_flat[i*IRW +: IRW]);
        end
        for (int j = 0; j < int'(OUT_W); j++) begin
            rdy_rank[j] = AW'(rdy_rank_flat[j*ORW +: ORW]);
        end
    end

    // Acceptance uses free = DEPTH - count only, so reads never feed back into it
    always_comb begin
        wr         = AW'(in_cnt);
        free_slots = AW'(DEPTH) - AW'(count_q);
        drop       = wr > free_slots;
        accepted   = drop ? free_slots : wr;
        avail      = AW'(count_q) + accepted;
        if (flush) begin
            rd = '0;
        end else begin
            rd = (AW'(rdy_cnt) < avail) ? AW'(rdy_cnt) : avail;
        end
    end

    // Dispatch: rank k reads head+k from storage, or bypasses the (k-count)th accepted input
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int j = 0; j < int'(OUT_W); j++) begin
            if (!flush && out_ready[j] && (rdy_rank[j] < avail)) begin
                out_valid[j] = 1'b1;
                if (rdy_rank[j] < AW'(count_q)) begin
                    out_data[j*DATA_W +: DATA_W] = mem_q[PW'(AW'(head_q) + rdy_rank[j])];
                end else begin
                    for (int i = 0; i < int'(IN_W); i++) begin
                        if (in_valid[i] && (in_rank[i] == (rdy_rank[j] - AW'(count_q)))) begin
                            out_data[j*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
    end

    // Storage writes and pointer/count/flag next state
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (!flush && in_valid[i] && (in_rank[i] < accepted)) begin
                mem_d[PW'(AW'(tail_q) + in_rank[i])] = in_data[i*DATA_W +: DATA_W];
            end
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = PW'(AW'(head_q) + rd);
            tail_d  = PW'(AW'(tail_q) + accepted);
            count_d = CW'(AW'(count_q) + accepted - rd);
        end
        overflow_d    = overflow_q | (!flush & drop);
        almost_full_d = AW'(count_d) >= AW'(DEPTH - AF_MARGIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Payload storage needs no reset: slots are only read below count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count       = count_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_fu_issue_fifo_n.sv
// Directed + randomized bench for fu_issue_fifo_n with a queue scoreboard.
module tb_fu_issue_fifo_n;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned IN_W  = 3;
    localparam int unsigned OUT_W = 3;
    localparam int unsigned DW    = 64;
    localparam int unsigned AFM   = IN_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [IN_W-1:0]   in_valid;
    logic [IN_W*DW-1:0] in_data;
    logic [OUT_W-1:0]  out_ready;
    logic [OUT_W-1:0]  out_valid;
    logic [OUT_W*DW-1:0] out_data;
    logic              almost_full;
    logic [3:0]        count;
    logic              overflow;

    logic [DW-1:0] sb [$];
    logic          exp_ovf;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] seq;

    always #5 clk = ~clk;

    fu_issue_fifo_n #(
        .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .DATA_W(DW), .AF_MARGIN(AFM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered state after the edge
    task automatic check_state();
        check("count", DW'(count), DW'(sb.size()));
        check("overflow", DW'(overflow), DW'(exp_ovf));
        check("almost_full", DW'(almost_full), DW'(sb.size() >= int'(DEPTH - AFM)));
    endtask

    // One cycle: drive, check combinational dispatch against scoreboard, clock, check state
    task automatic step(input logic fl, input logic [2:0] v,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [2:0] rdy);
        logic [DW-1:0] dd [3];
        int free_n;
        int acc;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        flush = fl; in_valid = v; in_data = {d2, d1, d0}; out_ready = rdy;
        #2;
        if (fl) begin
            check("flush_out_valid", DW'(out_valid), '0);
            for (int j = 0; j < int'(OUT_W); j++) begin
                check("flush_out_data", out_data[j*DW +: DW], '0);
            end
            sb.delete();
        end else begin
            free_n = int'(DEPTH) - sb.size();
            acc = 0;
            for (int i = 0; i < int'(IN_W); i++) begin
                if (v[i]) begin
                    if (acc < free_n) begin
                        sb.push_back(dd[i]);
                        acc++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
            for (int j = 0; j < int'(OUT_W); j++) begin
                if (rdy[j] && sb.size() > 0) begin
                    check("out_valid", DW'(out_valid[j]), DW'(1));
                    check("out_data", out_data[j*DW +: DW], sb.pop_front());
                end else begin
                    check("out_idle_valid", DW'(out_valid[j]), DW'(0));
                    check("out_idle_data", out_data[j*DW +: DW], '0);
                end
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = '0;
        exp_ovf = 1'b0;
        seq = 64'h100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_out_data", out_data[DW-1:0], '0);
        check_state();

        // Bypass on lane 0, then the stored B on lane 2
        step(1'b0, 3'b101, 64'hA, 64'hDEAD, 64'hB, 3'b001);
        step(1'b0, 3'b000, '0, '0, '0, 3'b100);

        // Fill to DEPTH-IN_W with no readers, then idle
        step(1'b0, 3'b111, 64'h11, 64'h12, 64'h13, 3'b000);
        step(1'b0, 3'b011, 64'h14, 64'h15, 64'h16, 3'b000);
        step(1'b0, 3'b000, '0, '0, '0, 3'b000);

        // Fill to full, then full + all ready + 3 pushes: all pushes dropped
        step(1'b0, 3'b111, 64'h17, 64'h18, 64'h19, 3'b000);
        step(1'b0, 3'b111, 64'h1A, 64'h1B, 64'h1C, 3'b111);

        // Steady 3-in / 3-out across pointer wrap
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 3'b111, seq, seq + 1, seq + 2, 3'b111);
            seq = seq + 3;
        end

        // Flush at count 6 with traffic, then bypass from empty
        step(1'b0, 3'b001, 64'h21, '0, '0, 3'b000);
        step(1'b1, 3'b111, 64'h22, 64'h23, 64'h24, 3'b111);
        step(1'b0, 3'b001, 64'h25, '0, '0, 3'b001);

        // Partial ready with a single entry
        step(1'b0, 3'b001, 64'h26, '0, '0, 3'b000);
        step(1'b0, 3'b000, '0, '0, '0, 3'b101);

        // Randomized traffic with occasional flush
        for (int c = 0; c < 80; c++) begin
            step(($urandom_range(0, 19) == 0), 3'($urandom), seq, seq + 1, seq + 2, 3'($urandom));
            seq = seq + 3;
        end

        // Reset clears sticky overflow and occupancy
        rst = 1'b1; flush = 1'b1; in_valid = '0; out_ready = '0;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
